ram_dc: RTL and testbench

RAM_DC -- requirements
Module: ram_dc

---
 rtl/ram_dc_pkg.sv | 18 +
 rtl/ram_dc.sv | 85 ++++++++
 tb/tb_ram_dc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ram_dc_pkg.sv
// ram_dc_pkg -- shared constants for the ram_dc dual-port RAM.
//
// Contents:
//   DATAWIDTH_DEF : default word width in bits
//   ADDRWIDTH_DEF : default address width in bits
//   DEPTH_DEF     : default depth in words, derived from ADDRWIDTH_DEF
//   depth_of()    : helper that returns the depth for any address width
package ram_dc_pkg;

  localparam int DATAWIDTH_DEF = 18;
  localparam int ADDRWIDTH_DEF = 5;
  localparam int DEPTH_DEF     = 2 ** ADDRWIDTH_DEF;

  function automatic int depth_of(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/ram_dc.sv
// ram_dc -- simple dual-port RAM with one clock and a registered read port.
//
// There is one write port and one read port. Both are sampled on the rising
// edge of clk. The read data shows up one cycle after the read address is
// sampled. The storage array is written only inside a clocked process, so
// synthesis can map it to block RAM in read-first mode.
//
// Handshake: none. The block accepts a write and a read on every cycle and
// never stalls. It has no valid, ready or busy signals.
//
// Reset (synchronous, active-high): rd_data is cleared and writes are
// blocked. The memory contents are kept, so data written before reset can
// still be read after it.
//
// Build option:
//   RAM_DC_BYPASS_EN -- when defined, a write and a read to the same address
//                       on the same edge return the new data (write-first).
//                       When not defined, the read returns the old contents
//                       (read-first), and no address comparator or bypass
//                       mux is built.
//
// Ports:
//   clk     in   1          clock for both ports
//   reset   in   1          synchronous active-high reset
//   wr_addr in   ADDRWIDTH  write address
//   wr_data in   DATAWIDTH  write data
//   we      in   1          write enable
//   rd_addr in   ADDRWIDTH  read address, sampled every cycle
//   rd_data out  DATAWIDTH  registered read data
module ram_dc
  import ram_dc_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDRWIDTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] rd_data_d;
  logic [DATAWIDTH-1:0] rd_data_q;
  logic                 wr_en;

  // Writes are blocked while reset is high. The memory itself is never
  // cleared.
  assign wr_en = we & ~reset;

  // The address has exactly ADDRWIDTH bits, so every value indexes a real
  // word. A caller's addr+1 wraps from all-ones back to 0 on its own.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem_q[rd_addr];
`ifdef RAM_DC_BYPASS_EN
    // Write-first: data being written to the address we are reading goes
    // straight to the output.
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_ram_dc.sv
module tb_ram_dc;

  localparam int DW = 18;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;

`ifdef RAM_DC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          we = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  ram_dc #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .we      (we),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- behavioural model ----------------
  // Contents of each word, plus a flag that says whether the bench has
  // written it yet. Power-up contents are undefined.
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_known [DEPTH];
  logic [DW-1:0] exp_rd = '0;
  bit            exp_known = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Apply one rising edge to the model, using the same inputs the DUT
  // sees. The read sees the memory as it was before the edge (the written
  // value is used only when same-address forwarding is enabled). The write
  // is applied after the read.
  task automatic model_edge();
    if (reset) begin
      exp_rd    = '0;
      exp_known = 1'b1;
    end else begin
      if (BYPASS && we && (wr_addr == rd_addr)) begin
        exp_rd    = wr_data;
        exp_known = 1'b1;
      end else begin
        exp_rd    = model_mem[rd_addr];
        exp_known = model_known[rd_addr];
      end
      if (we) begin
        model_mem[wr_addr]   = wr_data;
        model_known[wr_addr] = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. It drives the inputs, lets one rising
  // edge pass, updates the model, and returns at the next falling edge.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    reset   = r;
    we      = w;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  // Compare process: check the DUT against the model on every falling edge
  // where the expected value is defined.
  always @(negedge clk) begin
    if (exp_known) begin
      chk_cnt++;
      if (rd_data !== exp_rd) begin
        $display("FAIL model_rd t=%0t addr=%0d actual=%h required=%h",
                 $time, rd_addr, rd_data, exp_rd);
      end else begin
        pass_cnt++;
      end
    end
  end

  // Fixed expected values worked out by hand. These pin down the model
  // itself.
  task automatic check_lit(input string name, input logic [DW-1:0] req);
    chk_cnt++;
    if (rd_data !== req) begin
      $display("FAIL %s actual=%h required=%h", name, rd_data, req);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end
    @(negedge clk);

    // Reset: rd_data goes to 0.
    cyc(1'b1, 1'b0, 5'd0, 18'h0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 18'h0, 5'd0);
    check_lit("reset_zero", 18'h0);

    // Write 0x15555 to address 3, then read it back.
    cyc(1'b0, 1'b1, 5'd3, 18'h15555, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd3);
    check_lit("wr3_rd3", 18'h15555);

    // Write addr*3 to every address, then read them all back in order and
    // wrap from 31 to 0.
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b0, 1'b1, AW'(a), DW'(a * 3), 5'd0);
    end
    for (int a = 0; a <= DEPTH; a++) begin
      cyc(1'b0, 1'b0, 5'd0, 18'h0, AW'(a));
      if (a == 31) check_lit("fill_rd31", 18'h0005D);
      if (a == 32) check_lit("fill_wrap0", 18'h00000);
    end

    // Same-cycle write and read at address 7, which holds 1.
    cyc(1'b0, 1'b1, 5'd7, 18'h00001, 5'd0);
    cyc(1'b0, 1'b1, 5'd7, 18'h3FFFF, 5'd7);
    check_lit("rdw_same", BYPASS ? 18'h3FFFF : 18'h00001);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd7);
    check_lit("rdw_next", 18'h3FFFF);

    // Reset for two cycles with a write pending. The write must be blocked.
    cyc(1'b1, 1'b1, 5'd7, 18'h12345, 5'd7);
    check_lit("rst_mid1", 18'h0);
    cyc(1'b1, 1'b1, 5'd7, 18'h12345, 5'd7);
    check_lit("rst_mid2", 18'h0);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd7);
    check_lit("rst_keep7", 18'h3FFFF);

    // Write address 5 while reading address 6.
    cyc(1'b0, 1'b1, 5'd5, 18'h2ABCD, 5'd6);
    check_lit("rdw_diff6", 18'h00012);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd5);
    check_lit("rd5_new", 18'h2ABCD);

    // Keep the read address at 9 and write address 9 on cycle N.
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd9);
    check_lit("hold9_old", 18'h0001B);
    cyc(1'b0, 1'b1, 5'd9, 18'h00777, 5'd9);
    check_lit("hold9_n", BYPASS ? 18'h00777 : 18'h0001B);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd9);
    check_lit("hold9_n1", 18'h00777);

    // Back-to-back writes to the same address: the last one wins.
    cyc(1'b0, 1'b1, 5'd10, 18'h00001, 5'd0);
    cyc(1'b0, 1'b1, 5'd10, 18'h00002, 5'd0);
    cyc(1'b0, 1'b1, 5'd10, 18'h00003, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd10);
    check_lit("last_wins", 18'h00003);

    // The first edge after reset is released does a normal write and read.
    cyc(1'b1, 1'b0, 5'd0, 18'h0, 5'd0);
    cyc(1'b0, 1'b1, 5'd31, 18'h1F00F, 5'd2);
    check_lit("post_rst_rd2", 18'h00006);
    cyc(1'b0, 1'b0, 5'd0, 18'h0, 5'd31);
    check_lit("post_rst_wr31", 18'h1F00F);

    // Directed mixed traffic that only the model checks.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, (i % 3) != 0, AW'(i * 7), DW'(i * 1031 + 5), AW'(i * 5 + 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
